iter_alu: RTL

//  Parametrised sequential ALU for the multi-cycle datapath. Superset of the combinational ALU
//  (AND/OR/ADD/SUB/SLT) plus iterative multiply and divide with HI/LO result registers.

---
 rtl/iter_alu_if.sv | 20 ++
 rtl/iter_alu.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/iter_alu_if.sv
// Issue/result bundle for iter_alu: master issues start/op/a/b, slave returns results and status.
interface iter_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             dbz;
  logic             busy;
  logic             done;

  modport master (output start, op, a, b,
                  input  result, hi, zero, dbz, busy, done);
  modport slave  (input  start, op, a, b,
                  output result, hi, zero, dbz, busy, done);
endinterface

// File: rtl/iter_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus 1-bit/cycle multiply and restoring divide.
// Define ITER_ALU_SIGNED_MD_EN to make op codes 1010/1011 signed MULT/DIV.
module iter_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic      clk,
  input  logic      rst_n,
  iter_alu_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
  typedef enum logic [3:0] {
    OP_AND   = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010,
    OP_SUB   = 4'b0110, OP_SLT  = 4'b0111, OP_MULTU = 4'b1000,
    OP_DIVU  = 4'b1001, OP_MULT = 4'b1010, OP_DIV   = 4'b1011
  } op_e;

  state_e             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_acc, r_lo, r_opnd;
  logic               r_neg_lo, r_neg_hi;
  logic [WIDTH-1:0]   r_result, r_hi;
  logic               r_zero, r_dbz;

  logic               w_is_mul, w_is_div, w_signed, w_b_zero;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_alu_res;

  logic [WIDTH:0]     w_sum, w_rem_sh, w_diff;
  logic [WIDTH-1:0]   w_acc_nx, w_lo_nx, w_fin_res, w_fin_hi;
  logic [2*WIDTH-1:0] w_prod, w_prod_f;
  logic               w_last;

  always_comb begin
    w_is_mul  = 1'b0;
    w_is_div  = 1'b0;
    w_signed  = 1'b0;
    w_alu_res = '0;
    case (bus.op)
      OP_AND:   w_alu_res = bus.a & bus.b;
      OP_OR:    w_alu_res = bus.a | bus.b;
      OP_ADD:   w_alu_res = bus.a + bus.b;
      OP_SUB:   w_alu_res = bus.a + ~bus.b + WIDTH'(1);
      OP_SLT:   w_alu_res = WIDTH'($signed(bus.a) < $signed(bus.b));
      OP_MULTU: w_is_mul  = 1'b1;
      OP_DIVU:  w_is_div  = 1'b1;
`ifdef ITER_ALU_SIGNED_MD_EN
      OP_MULT: begin
        w_is_mul = 1'b1;
        w_signed = 1'b1;
      end
      OP_DIV: begin
        w_is_div = 1'b1;
        w_signed = 1'b1;
      end
`endif
      default:  w_alu_res = '0;
    endcase
    w_b_zero = (bus.b == '0);
    w_a_neg  = w_signed & bus.a[WIDTH-1];
    w_b_neg  = w_signed & bus.b[WIDTH-1];
    w_a_mag  = w_a_neg ? -bus.a : bus.a;
    w_b_mag  = w_b_neg ? -bus.b : bus.b;
  end

  // One iteration of the unsigned core; on the last one the sign fix-up feeds the outputs directly.
  always_comb begin
    w_sum    = {1'b0, r_acc} + {1'b0, (r_lo[0] ? r_opnd : '0)};
    w_rem_sh = {r_acc, r_lo[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_opnd};
    if (r_state == S_MUL) begin
      w_acc_nx = w_sum[WIDTH:1];
      w_lo_nx  = {w_sum[0], r_lo[WIDTH-1:1]};
    end else if (!w_diff[WIDTH]) begin
      w_acc_nx = w_diff[WIDTH-1:0];
      w_lo_nx  = {r_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_acc_nx = w_rem_sh[WIDTH-1:0];
      w_lo_nx  = {r_lo[WIDTH-2:0], 1'b0};
    end
    w_prod   = {w_acc_nx, w_lo_nx};
    w_prod_f = r_neg_lo ? -w_prod : w_prod;
    if (r_state == S_MUL) begin
      w_fin_res = w_prod_f[WIDTH-1:0];
      w_fin_hi  = w_prod_f[2*WIDTH-1:WIDTH];
    end else begin
      w_fin_res = r_neg_lo ? -w_lo_nx : w_lo_nx;
      w_fin_hi  = r_neg_hi ? -w_acc_nx : w_acc_nx;
    end
    w_last = (r_cnt == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_is_mul)                   w_state_nx = S_MUL;
          else if (w_is_div && !w_b_zero) w_state_nx = S_DIV;
          else                            w_state_nx = S_DONE;
        end
      end
      S_MUL, S_DIV: if (w_last) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_result <= '0;
      r_hi     <= '0;
      r_zero   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= w_is_mul ? w_a_mag : w_b_mag;
            r_lo     <= w_is_mul ? w_b_mag : w_a_mag;
            r_neg_lo <= w_a_neg ^ w_b_neg;
            r_neg_hi <= w_is_div & w_a_neg;
            if (w_is_div && w_b_zero) begin
              r_result <= '1;
              r_hi     <= bus.a;
              r_zero   <= 1'b0;
              r_dbz    <= 1'b1;
            end else if (!w_is_mul && !w_is_div) begin
              r_result <= w_alu_res;
              r_hi     <= '0;
              r_zero   <= (w_alu_res == '0);
              r_dbz    <= 1'b0;
            end
          end
        end
        S_MUL, S_DIV: begin
          r_acc <= w_acc_nx;
          r_lo  <= w_lo_nx;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_result <= w_fin_res;
            r_hi     <= w_fin_hi;
            r_zero   <= (w_fin_res == '0);
            r_dbz    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.hi     = r_hi;
  assign bus.zero   = r_zero;
  assign bus.dbz    = r_dbz;
  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = (r_state == S_DONE);
endmodule
